// File: rtl/ldm_stm_sequencer_if.sv
// Bundles the block-transfer request, register-file and memory-beat signals of the LDM/STM sequencer.
// The master modport is the sequencer; the slave modport is the core/memory side.
interface ldm_stm_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic              is_load;
    logic              pre;
    logic              up;
    logic              wback;
    logic [3:0]        rn;
    logic [DATA_W-1:0] base;
    logic [15:0]       reg_list;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [3:0]        r_addr;
    logic [3:0]        w_addr;
    logic [DATA_W-1:0] w_data;
    logic              write_reg;
    logic              write_pc;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              done;

    modport master (
        input  start, is_load, pre, up, wback, rn, base, reg_list,
        input  r_data, mem_rdata, mem_ready,
        output r_addr, w_addr, w_data, write_reg, write_pc,
        output mem_req, mem_we, mem_addr, mem_wdata, busy, done
    );

    modport slave (
        output start, is_load, pre, up, wback, rn, base, reg_list,
        output r_data, mem_rdata, mem_ready,
        input  r_addr, w_addr, w_data, write_reg, write_pc,
        input  mem_req, mem_we, mem_addr, mem_wdata, busy, done
    );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// Multi-register load/store sequencer: walks a 16-bit register list in ascending order,
// issuing one memory beat per selected register, then optionally writes the updated base back.
module ldm_stm_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    ldm_stm_sequencer_if.master  bus
);
    typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;

    state_t            state, state_next;
    logic              is_load_q;
    logic              wback_q;
    logic              rn_hit_q;
    logic [3:0]        rn_q;
    logic [15:0]       list_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wb_val_q;

    logic [4:0]        cnt;
    logic [DATA_W-1:0] cnt_x4;
    logic [DATA_W-1:0] start_addr;
    logic [DATA_W-1:0] wb_val;
    logic [3:0]        cur;
    logic [15:0]       list_next;

    // The block always occupies the address window [lowest, lowest+4*cnt); only its lower end depends on P/U.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(bus.reg_list[i]);
        end
        cnt_x4 = {{(DATA_W-7){1'b0}}, cnt, 2'b00};
        case ({bus.pre, bus.up})
            2'b01:   start_addr = bus.base;
            2'b11:   start_addr = bus.base + DATA_W'(4);
            2'b00:   start_addr = bus.base - cnt_x4 + DATA_W'(4);
            default: start_addr = bus.base - cnt_x4;
        endcase
        wb_val = bus.up ? (bus.base + cnt_x4) : (bus.base - cnt_x4);
    end

    always_comb begin
        cur = '0;
        for (int i = 15; i >= 0; i--) begin
            if (list_q[i]) begin
                cur = 4'(i);
            end
        end
        list_next = list_q & ~(16'h0001 << cur);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            is_load_q <= 1'b0;
            wback_q   <= 1'b0;
            rn_hit_q  <= 1'b0;
            rn_q      <= '0;
            list_q    <= '0;
            addr_q    <= '0;
            wb_val_q  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && bus.start) begin
                is_load_q <= bus.is_load;
                wback_q   <= bus.wback;
                rn_hit_q  <= bus.reg_list[bus.rn];
                rn_q      <= bus.rn;
                list_q    <= bus.reg_list;
                addr_q    <= start_addr;
                wb_val_q  <= wb_val;
            end else if (state == XFER && bus.mem_ready) begin
                list_q <= list_next;
                addr_q <= addr_q + DATA_W'(4);
            end
        end
    end

    always_comb begin
        state_next    = state;
        bus.r_addr    = '0;
        bus.w_addr    = '0;
        bus.w_data    = '0;
        bus.write_reg = 1'b0;
        bus.write_pc  = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.busy      = (state != IDLE);
        bus.done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (cnt != 5'd0) ? XFER : DONE;
                end
            end
            XFER: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = ~is_load_q;
                bus.mem_addr  = addr_q;
                bus.r_addr    = cur;
                bus.mem_wdata = is_load_q ? '0 : bus.r_data;
                if (bus.mem_ready) begin
                    if (is_load_q) begin
                        bus.w_data = bus.mem_rdata;
                        if (cur == 4'd15) begin
                            bus.write_pc = 1'b1;
                        end else begin
                            bus.write_reg = 1'b1;
                            bus.w_addr    = cur;
                        end
                    end
                    if (list_next == 16'h0000) begin
                        state_next = wback_q ? WB : DONE;
                    end
                end
            end
            WB: begin
                // A loaded rn already holds its new value, and the PC is never a writeback target.
                if (rn_q != 4'd15 && !(is_load_q && rn_hit_q)) begin
                    bus.write_reg = 1'b1;
                    bus.w_addr    = rn_q;
                    bus.w_data    = wb_val_q;
                end
                state_next = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed self-checking bench for ldm_stm_sequencer: STM/LDM in all addressing flavours,
// wait states, writeback suppression, empty list, mid-transfer reset, ignored start and address wrap.
module tb_ldm_stm_sequencer;
    logic clk;
    logic rst;
    int   checkCount;
    int   errorCount;

    ldm_stm_sequencer_if #(.DATA_W(32)) bus ();

    ldm_stm_sequencer #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file and memory responders: each returns data tagged by the address it was asked for.
    assign bus.r_data    = 32'hA000_0000 | 32'(bus.r_addr);
    assign bus.mem_rdata = 32'hD000_0000 ^ bus.mem_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic pr, input logic u, input logic wb,
                                 input logic [3:0] rnv, input logic [31:0] b, input logic [15:0] list);
        bus.start    = 1'b1;
        bus.is_load  = ld;
        bus.pre      = pr;
        bus.up       = u;
        bus.wback    = wb;
        bus.rn       = rnv;
        bus.base     = b;
        bus.reg_list = list;
    endtask

    // Advance one clock and settle 1ns past the edge; start is a one-cycle pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, " done"}, 32'(bus.done), 32'd0);
        checkOutput({tag, " mem_req"}, 32'(bus.mem_req), 32'd0);
        checkOutput({tag, " write_reg"}, 32'(bus.write_reg), 32'd0);
    endtask

    task automatic checkBeat(input string tag, input logic [31:0] addr, input logic [3:0] ra,
                             input logic we);
        checkOutput({tag, " mem_req"}, 32'(bus.mem_req), 32'd1);
        checkOutput({tag, " mem_we"}, 32'(bus.mem_we), 32'(we));
        checkOutput({tag, " mem_addr"}, bus.mem_addr, addr);
        checkOutput({tag, " r_addr"}, 32'(bus.r_addr), 32'(ra));
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 16'h0);
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkIdle("reset");
        checkOutput("reset mem_addr", bus.mem_addr, 32'h0);
        checkOutput("reset w_data", bus.w_data, 32'h0);
        checkOutput("reset mem_wdata", bus.mem_wdata, 32'h0);

        // STM IA r0,r1,r4 from 0x100
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 32'h100, 16'h0013);
        tick();
        checkBeat("stmia b0", 32'h100, 4'd0, 1'b1);
        checkOutput("stmia b0 wdata", bus.mem_wdata, 32'hA000_0000);
        checkOutput("stmia b0 busy", 32'(bus.busy), 32'd1);
        tick();
        checkBeat("stmia b1", 32'h104, 4'd1, 1'b1);
        checkOutput("stmia b1 wdata", bus.mem_wdata, 32'hA000_0001);
        tick();
        checkBeat("stmia b2", 32'h108, 4'd4, 1'b1);
        checkOutput("stmia b2 wdata", bus.mem_wdata, 32'hA000_0004);
        checkOutput("stmia b2 write_reg", 32'(bus.write_reg), 32'd0);
        tick();
        checkOutput("stmia done", 32'(bus.done), 32'd1);
        checkOutput("stmia done mem_req", 32'(bus.mem_req), 32'd0);
        tick();
        checkIdle("stmia after");

        // LDM DB r0,r1,pc from 0x200 with writeback to r13
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 32'h200, 16'h8003);
        tick();
        checkBeat("ldmdb b0", 32'h1F4, 4'd0, 1'b0);
        checkOutput("ldmdb b0 write_reg", 32'(bus.write_reg), 32'd1);
        checkOutput("ldmdb b0 w_addr", 32'(bus.w_addr), 32'd0);
        checkOutput("ldmdb b0 w_data", bus.w_data, 32'hD000_01F4);
        tick();
        checkBeat("ldmdb b1", 32'h1F8, 4'd1, 1'b0);
        checkOutput("ldmdb b1 w_addr", 32'(bus.w_addr), 32'd1);
        checkOutput("ldmdb b1 w_data", bus.w_data, 32'hD000_01F8);
        tick();
        checkBeat("ldmdb b2", 32'h1FC, 4'd15, 1'b0);
        checkOutput("ldmdb b2 write_pc", 32'(bus.write_pc), 32'd1);
        checkOutput("ldmdb b2 write_reg", 32'(bus.write_reg), 32'd0);
        checkOutput("ldmdb b2 w_data", bus.w_data, 32'hD000_01FC);
        tick();
        checkOutput("ldmdb wb write_reg", 32'(bus.write_reg), 32'd1);
        checkOutput("ldmdb wb w_addr", 32'(bus.w_addr), 32'd13);
        checkOutput("ldmdb wb w_data", bus.w_data, 32'h1F4);
        checkOutput("ldmdb wb mem_req", 32'(bus.mem_req), 32'd0);
        tick();
        checkOutput("ldmdb done", 32'(bus.done), 32'd1);
        checkOutput("ldmdb done write_reg", 32'(bus.write_reg), 32'd0);
        tick();
        checkIdle("ldmdb after");

        // LDM IA r1,r2 from 0x40 with three wait cycles per beat
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 32'h40, 16'h0006);
        bus.mem_ready = 1'b0;
        tick();
        for (int beat = 0; beat < 2; beat++) begin
            for (int w = 0; w < 3; w++) begin
                checkBeat($sformatf("wait b%0d w%0d", beat, w), 32'h40 + 32'(4 * beat), 4'(beat + 1), 1'b0);
                checkOutput($sformatf("wait b%0d w%0d write_reg", beat, w), 32'(bus.write_reg), 32'd0);
                tick();
            end
            bus.mem_ready = 1'b1;
            #1;
            checkOutput($sformatf("ready b%0d write_reg", beat), 32'(bus.write_reg), 32'd1);
            checkOutput($sformatf("ready b%0d w_addr", beat), 32'(bus.w_addr), 32'(beat + 1));
            checkOutput($sformatf("ready b%0d w_data", beat), bus.w_data, 32'hD000_0040 + 32'(4 * beat));
            tick();
            bus.mem_ready = (beat == 0) ? 1'b0 : 1'b1;
            #1;
        end
        checkOutput("wait done", 32'(bus.done), 32'd1);
        tick();

        // Empty list completes without beats
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 32'h80, 16'h0000);
        tick();
        checkOutput("empty done", 32'(bus.done), 32'd1);
        checkOutput("empty mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("empty write_reg", 32'(bus.write_reg), 32'd0);
        tick();
        checkIdle("empty after");

        // LDM IA with rn=2 in the list: loaded value wins, writeback suppressed
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 32'h300, 16'h0004);
        tick();
        checkBeat("rnin b0", 32'h300, 4'd2, 1'b0);
        checkOutput("rnin b0 w_addr", 32'(bus.w_addr), 32'd2);
        checkOutput("rnin b0 w_data", bus.w_data, 32'hD000_0300);
        tick();
        checkOutput("rnin wb busy", 32'(bus.busy), 32'd1);
        checkOutput("rnin wb write_reg", 32'(bus.write_reg), 32'd0);
        tick();
        checkOutput("rnin done", 32'(bus.done), 32'd1);
        tick();

        // Reset during the 2nd beat of a 4-beat STM
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd6, 32'h500, 16'h000F);
        tick();
        tick();
        checkBeat("abort b1", 32'h504, 4'd1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkIdle("abort");
        checkOutput("abort mem_addr", bus.mem_addr, 32'h0);
        tick();
        checkIdle("abort later");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 32'h600, 16'h0001);
        tick();
        checkBeat("restart b0", 32'h604, 4'd0, 1'b1);
        tick();
        checkOutput("restart done", 32'(bus.done), 32'd1);
        tick();

        // STM DA wrapping below zero, with start pulses ignored during the transfer
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 32'h4, 16'h000F);
        tick();
        for (int beat = 0; beat < 4; beat++) begin
            checkBeat($sformatf("wrap b%0d", beat), 32'hFFFF_FFF8 + 32'(4 * beat), 4'(beat), 1'b1);
            checkOutput($sformatf("wrap b%0d wdata", beat), bus.mem_wdata, 32'hA000_0000 + 32'(beat));
            @(posedge clk);
            #1;
            if (beat < 3) begin
                applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 32'h7000, 16'h00F0);
            end else begin
                bus.start = 1'b0;
            end
            #1;
        end
        checkOutput("wrap done", 32'(bus.done), 32'd1);
        checkOutput("wrap done mem_req", 32'(bus.mem_req), 32'd0);
        tick();
        checkIdle("wrap after");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule

// File: doc/ldm_stm_sequencer.md
LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

Interface
- REQ-001 SHALL have parameter DATA_W, default 32, meaning data and address width.
- REQ-002 SHALL have ports:
  - clk  in  1  single clock; all state updates on posedge clk.
  - rst  in  1  reset, synchronous, active-high.
  - start  in  1  request a block transfer; accepted only in IDLE.
  - is_load  in  1  1 = LDM (memory to registers), 0 = STM (registers to memory).
  - pre  in  1  P bit: 1 = before, 0 = after.
  - up  in  1  U bit: 1 = increment, 0 = decrement.
  - wback  in  1  W bit: write the updated base back to rn.
  - rn  in  4  base register number.
  - base  in  DATA_W  base register value.
  - reg_list  in  16  register list; bit i selects ri.
  - r_data  in  DATA_W  register-file read data for r_addr.
  - mem_rdata  in  DATA_W  memory read data.
  - mem_ready  in  1  memory accepts or returns the current beat.
  - r_addr  out  4  register-file read address.
  - w_addr  out  4  register-file write address.
  - w_data  out  DATA_W  register-file write data.
  - write_reg  out  1  register-file write strobe for r0-r14.
  - write_pc  out  1  PC write strobe, with w_data as the PC value.
  - mem_req  out  1  memory beat request.
  - mem_we  out  1  memory write enable.
  - mem_addr  out  DATA_W  word address of the beat.
  - mem_wdata  out  DATA_W  store data.
  - busy  out  1  high in any state other than IDLE.
  - done  out  1  single-cycle completion pulse.

Function
- REQ-003 SHALL implement states IDLE, XFER, WB and DONE.
- REQ-004 SHALL, in IDLE with start=1, capture is_load, pre, up, wback, rn, base and reg_list; compute cnt = popcount(reg_list) (0..16); go to XFER if cnt>0, else DONE.
- REQ-005 SHALL compute start address modulo 2^DATA_W:
  - IA: base.
  - IB: base+4.
  - DA: base-4*cnt+4.
  - DB: base-4*cnt.
- REQ-006 SHALL issue beats in ascending address order, lowest-numbered selected register first, with mem_addr incrementing by 4 per accepted beat.
- REQ-007 SHALL, in XFER, hold mem_req=1, mem_we=~is_load and a stable mem_addr until mem_ready=1 at a posedge; any number of wait cycles is legal.
- REQ-008 SHALL drive r_addr = current register for the whole beat and mem_wdata = r_data for stores.
- REQ-009 SHALL handle a load beat where mem_ready=1 in the same cycle:
  - current register 0-14: assert write_reg=1, w_addr = current register, w_data = mem_rdata.
  - current register 15: assert write_pc=1 and write_reg=0.
- REQ-010 SHALL clear the current register's bit after each accepted beat; the last accepted beat goes to WB if wback=1, else DONE.
- REQ-011 SHALL, in WB, drive write_reg=1, w_addr=rn and w_data = base±4*cnt (+ if up) for exactly one cycle, then go to DONE.
- REQ-012 SHALL suppress the WB write when is_load=1 and rn is in reg_list (loaded value wins) and when rn=15; WB still takes its one cycle.
- REQ-013 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE.
- REQ-014 SHALL ignore start while busy=1.
- REQ-015 SHALL keep write_reg, write_pc, mem_req, mem_we and done low outside the cases in REQ-007 to REQ-013.
- REQ-016 SHALL complete an empty list with no memory beats, no register writes and no WB in 2 cycles (IDLE→DONE→IDLE).
- REQ-017 SHALL keep the STM store data as the pre-instruction value when rn is in reg_list, since WB occurs after all beats.

Reset
- REQ-018 SHALL, on rst=1 at posedge clk, enter IDLE with every output 0 (r_addr, w_addr, w_data, mem_addr, mem_wdata = 0), regardless of state.
- REQ-019 SHALL treat reset mid-transfer as an abandon: no further beats, no WB write and no done pulse.

Verification
- REQ-020 SHALL cover STM IA: base=0x100, reg_list=0x0013, mem_ready always 1 → beats r0@0x100, r1@0x104, r4@0x108; done 4 cycles after start.
- REQ-021 SHALL cover LDM DB with writeback: base=0x200, rn=13, reg_list=0x8003, wback=1 → addresses 0x1F4, 0x1F8, 0x1FC; write_reg for r0 and r1; write_pc on the third beat; WB writes r13=0x1F4.
- REQ-022 SHALL cover wait states: 3 cycles of mem_ready=0 per beat → mem_req, mem_addr and r_addr stay stable; no write strobes until ready.
- REQ-023 SHALL cover empty list plus LDM with rn in the list:
  - reg_list=0 → done pulse 1 cycle after start, no mem_req.
  - LDM IA with rn=2, reg_list=0x0004, wback=1 → r2 = loaded value, no WB write.
- REQ-024 SHALL cover reset mid-op: rst asserted during the 2nd beat of a 4-beat STM → next cycle busy=0, mem_req=0, no done; a fresh start is then accepted normally.
- REQ-025 SHALL cover start while busy and wrap: start pulses during XFER are ignored; DA with base=0x4 and cnt=4 wraps the start address to 0xFFFFFFF8.
